// File: rtl/filter_ram_reader.sv
// filter_ram_reader
// Reads a burst of words from a synchronous RAM (one-cycle read latency)
// and streams the low PIX_W bits of each word out over a valid/ready
// interface. A two-entry output FIFO absorbs downstream back-pressure.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : begin a burst (sampled only while idle)
//   base_addr      : first RAM address of the burst
//   count          : number of words to read, 0..2^ADDR_W
//   rd, addr       : RAM read strobe and address
//   ram_data       : RAM read data, valid the cycle after rd
//   out_data       : streamed pixel (FIFO head)
//   out_valid      : out_data valid
//   out_ready      : downstream accept
//   out_last       : final pixel of the burst
//   busy           : burst in progress
//   done           : one-cycle pulse after the last pixel handshake
//   trunc_err      : sticky, a read word had bits set above PIX_W
module filter_ram_reader #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32,
    parameter int PIX_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] ram_data,
    output logic [PIX_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              trunc_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

    state_t          state;
    logic [ADDR_W:0] rem;          // reads still to issue
    logic            rd_q;         // a read issued last cycle; its data is on ram_data now
    logic            rd_q_last;    // that read was the final one of the burst

    // FIFO entry: {last flag, pixel}
    logic [PIX_W:0]  fifo_mem [0:1];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      fifo_cnt;

    logic            push;
    logic            pop;
    logic [2:0]      occ;

    assign push      = rd_q;
    assign out_valid = (fifo_cnt != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_data  = fifo_mem[rd_ptr][PIX_W-1:0];
    assign out_last  = out_valid & fifo_mem[rd_ptr][PIX_W];

    // Buffered words plus the read in flight, less the word leaving this
    // cycle. Crediting the same-cycle pop is what lets a 2-entry FIFO keep
    // up with one pixel per cycle, so rd is decoded from current state
    // rather than registered.
    assign occ = {1'b0, fifo_cnt} + {2'b00, rd_q} - {2'b00, pop};
    assign rd  = (state == READ) && (occ < 3'd2);

    // Control FSM, address/remaining counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem       <= '0;
            addr      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_q      <= 1'b0;
            rd_q_last <= 1'b0;
        end else begin
            rd_q      <= rd;
            rd_q_last <= rd && (rem == REM_ONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        rem  <= count;
                        addr <= base_addr;
                        busy <= 1'b1;
                        if (count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (rd) begin
                        addr <= addr + ADDR_W'(1);
                        rem  <= rem - REM_ONE;
                        if (rem == REM_ONE) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Output FIFO: each word lands the cycle after its read. The truncation
    // flag clears on an accepted start and sets on any pushed word that has
    // bits above the pixel field; pushes never coincide with a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
            trunc_err   <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                trunc_err <= 1'b0;
            end
            if (push) begin
                fifo_mem[wr_ptr] <= {rd_q_last, ram_data[PIX_W-1:0]};
                wr_ptr           <= ~wr_ptr;
                if (|ram_data[WORD_W-1:PIX_W]) begin
                    trunc_err <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule
